// File: rtl/timer_seq.sv
// timer_seq: command sequencer and bus arbiter for the PICO16a interval timer.
//
// Expands one-cycle host commands (START/STOP/SNAPSHOT/ACK) into the register
// write sequences the timer expects. It shares the timer bus port between the
// CPU and its own sequencer. It can also acknowledge timer interrupts on its
// own and count them as ticks.
//
// Ports:
//   cpu_clk, rst           clock; asynchronous active-low reset
//   cmd_valid/cmd_ready    command handshake; cmd_op selects the operation,
//                          and cmd_value is the START reload value
//   done                   one-cycle pulse when a host command finishes
//   rd_data                last SNAPSHOT result, held until the next one
//   auto_ack, irq          self-acknowledge enable; masked interrupt to the CPU
//   tick, tick_count       pulse and wrapping count of self-acknowledged irqs
//   cpu_*                  CPU side of the timer bus; cpu_wait while busy
//   t_*                    timer slave port; t_int_req is the timer interrupt
`timescale 1ns/1ps

module timer_seq #(
  parameter int TICK_W = 16
) (
  input  logic              cpu_clk,
  input  logic              rst,
  input  logic              cmd_valid,
  input  logic [1:0]        cmd_op,
  input  logic [31:0]       cmd_value,
  output logic              cmd_ready,
  output logic              done,
  output logic [31:0]       rd_data,
  input  logic              auto_ack,
  output logic              irq,
  output logic              tick,
  output logic [TICK_W-1:0] tick_count,
  input  logic              cpu_cs,
  input  logic              cpu_we,
  input  logic [2:0]        cpu_adrs,
  input  logic [15:0]       cpu_wdata,
  output logic [15:0]       cpu_rdata,
  output logic              cpu_wait,
  output logic              t_cs,
  output logic              t_we,
  output logic [2:0]        t_adrs,
  output logic [15:0]       t_wdata,
  input  logic [15:0]       t_rdata,
  input  logic              t_int_req
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEQ,
    S_RDH,
    S_RDL,
    S_DONE
  } state_t;

  typedef enum logic [1:0] {
    OP_START = 2'b00,
    OP_STOP  = 2'b01,
    OP_SNAP  = 2'b10,
    OP_ACK   = 2'b11
  } op_t;

  // Timer register map and control-word bits {read, init_load, init_we, run}.
  localparam logic [2:0]  A_HI   = 3'd0;
  localparam logic [2:0]  A_LO   = 3'd1;
  localparam logic [2:0]  A_CTRL = 3'd2;
  localparam logic [2:0]  A_ACK  = 3'd4;
  localparam logic [15:0] CTRL_RUN       = 16'h0001;
  localparam logic [15:0] CTRL_INIT_WE   = 16'h0002;
  localparam logic [15:0] CTRL_INIT_LOAD = 16'h0004;
  localparam logic [15:0] CTRL_READ      = 16'h0008;

  state_t              state_q, state_d;
  logic [2:0]          step_q, step_d;
  op_t                 op_q, op_d;
  logic                auto_q, auto_d;          // current sequence is a self-ack
  logic [31:0]         value_q, value_d;
  logic                run_shadow_q, run_shadow_d;
  logic [15:0]         hi_q, hi_d;
  logic [31:0]         rd_data_q, rd_data_d;
  logic [TICK_W-1:0]   tick_count_q, tick_count_d;

  logic                auto_pend;
  logic                seq_wr;
  logic                seq_last;
  logic [2:0]          seq_adrs;
  logic [15:0]         seq_data;
  logic [15:0]         shadow_word;

  assign auto_pend   = auto_ack & t_int_req;
  assign shadow_word = {15'd0, run_shadow_q};
  assign irq         = t_int_req & ~auto_ack;
  assign cpu_rdata   = t_rdata;
  assign tick_count  = tick_count_q;

  // Step table for the write sequences. Steps with seq_wr=0 are idle bus
  // cycles. seq_last marks the final step of the write phase.
  // NOTE: every combinational output gets a default before the case, so no
  // path leaves a value unassigned and no latch is inferred.
  always_comb begin
    seq_wr   = 1'b0;
    seq_last = 1'b0;
    seq_adrs = A_CTRL;
    seq_data = 16'h0000;
    case (op_q)
      OP_START: begin
        case (step_q)
          3'd0: begin seq_wr = 1'b1; seq_data = CTRL_INIT_WE; end
          3'd1: begin seq_wr = 1'b1; seq_adrs = A_HI; seq_data = value_q[31:16]; end
          3'd2: begin seq_wr = 1'b1; seq_adrs = A_LO; seq_data = value_q[15:0]; end
          3'd3: begin seq_wr = 1'b1; seq_data = CTRL_INIT_LOAD; end
          3'd4, 3'd5: ;  // two idle cycles let the timer finish the load
          3'd6: begin seq_wr = 1'b1; seq_data = CTRL_RUN; seq_last = 1'b1; end
          default: seq_last = 1'b1;
        endcase
      end
      OP_STOP: begin
        seq_wr   = 1'b1;
        seq_last = 1'b1;
      end
      OP_ACK: begin
        seq_wr   = 1'b1;
        seq_adrs = A_ACK;
        seq_last = 1'b1;
      end
      OP_SNAP: begin
        case (step_q)
          3'd0: begin seq_wr = 1'b1; seq_data = CTRL_READ | shadow_word; end
          3'd1: ;
          3'd2: begin seq_wr = 1'b1; seq_data = shadow_word; seq_last = 1'b1; end
          default: seq_last = 1'b1;
        endcase
      end
      default: seq_last = 1'b1;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    step_d       = step_q;
    op_d         = op_q;
    auto_d       = auto_q;
    value_d      = value_q;
    run_shadow_d = run_shadow_q;
    hi_d         = hi_q;
    rd_data_d    = rd_data_q;
    tick_count_d = tick_count_q;
    cmd_ready    = 1'b0;
    done         = 1'b0;
    tick         = 1'b0;
    cpu_wait     = 1'b1;
    t_cs         = 1'b0;
    t_we         = 1'b0;
    t_adrs       = 3'd0;
    t_wdata      = 16'h0000;
    rd_data      = rd_data_q;

    case (state_q)
      S_IDLE: begin
        cpu_wait  = 1'b0;
        t_cs      = cpu_cs;
        t_we      = cpu_we;
        t_adrs    = cpu_adrs;
        t_wdata   = cpu_wdata;
        cmd_ready = ~auto_pend;
        if (cpu_cs && cpu_we && cpu_adrs == A_CTRL) begin
          run_shadow_d = cpu_wdata[0];
        end
        // A pending self-ack wins over a host command in the same cycle.
        if (auto_pend) begin
          state_d = S_SEQ;
          step_d  = 3'd0;
          op_d    = OP_ACK;
          auto_d  = 1'b1;
        end else if (cmd_valid) begin
          state_d = S_SEQ;
          step_d  = 3'd0;
          op_d    = op_t'(cmd_op);
          auto_d  = 1'b0;
          value_d = cmd_value;
          if (op_t'(cmd_op) == OP_START) run_shadow_d = 1'b1;
          if (op_t'(cmd_op) == OP_STOP)  run_shadow_d = 1'b0;
        end
      end
      S_SEQ: begin
        t_cs    = seq_wr;
        t_we    = seq_wr;
        t_adrs  = seq_adrs;
        t_wdata = seq_data;
        if (seq_last) begin
          state_d = (op_q == OP_SNAP) ? S_RDH : S_DONE;
        end else begin
          step_d = step_q + 3'd1;
        end
      end
      S_RDH: begin
        t_cs    = 1'b1;
        t_adrs  = A_HI;
        state_d = S_RDL;
      end
      S_RDL: begin
        // t_rdata lags the address by one cycle, so it now holds the high half.
        t_cs    = 1'b1;
        t_adrs  = A_LO;
        hi_d    = t_rdata;
        state_d = S_DONE;
      end
      S_DONE: begin
        done = ~auto_q;
        tick = auto_q;
        if (auto_q) begin
          tick_count_d = tick_count_q + TICK_W'(1);
        end else if (op_q == OP_SNAP) begin
          // The low half arrives this cycle; present it together with done.
          rd_data   = {hi_q, t_rdata};
          rd_data_d = {hi_q, t_rdata};
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge cpu_clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      step_q       <= 3'd0;
      op_q         <= OP_START;
      auto_q       <= 1'b0;
      value_q      <= 32'h0;
      run_shadow_q <= 1'b0;
      hi_q         <= 16'h0;
      rd_data_q    <= 32'h0;
      tick_count_q <= '0;
    end else begin
      state_q      <= state_d;
      step_q       <= step_d;
      op_q         <= op_d;
      auto_q       <= auto_d;
      value_q      <= value_d;
      run_shadow_q <= run_shadow_d;
      hi_q         <= hi_d;
      rd_data_q    <= rd_data_d;
      tick_count_q <= tick_count_d;
    end
  end

endmodule

// File: tb/tb_timer_seq.sv
// Self-checking bench for timer_seq: it uses a table of command vectors, hand
// sequences for the corner cases, and randomized traffic checked against a
// command-level model of the expected bus writes and results.
`timescale 1ns/1ps

module tb_timer_seq;

  localparam int TW = 4;  // narrow tick counter so wrap-around is reachable

  logic          cpu_clk = 1'b0;
  logic          rst = 1'b0;
  logic          cmd_valid, cmd_ready, done;
  logic [1:0]    cmd_op;
  logic [31:0]   cmd_value, rd_data;
  logic          auto_ack, irq, tick;
  logic [TW-1:0] tick_count;
  logic          cpu_cs, cpu_we, cpu_wait;
  logic [2:0]    cpu_adrs;
  logic [15:0]   cpu_wdata, cpu_rdata;
  logic          t_cs, t_we;
  logic [2:0]    t_adrs;
  logic [15:0]   t_wdata;
  logic [15:0]   t_rdata = 16'h0;
  logic          t_int_req;

  timer_seq #(.TICK_W(TW)) dut (
    .cpu_clk(cpu_clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_value(cmd_value),
    .cmd_ready(cmd_ready), .done(done), .rd_data(rd_data),
    .auto_ack(auto_ack), .irq(irq), .tick(tick), .tick_count(tick_count),
    .cpu_cs(cpu_cs), .cpu_we(cpu_we), .cpu_adrs(cpu_adrs), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_wait(cpu_wait),
    .t_cs(t_cs), .t_we(t_we), .t_adrs(t_adrs), .t_wdata(t_wdata),
    .t_rdata(t_rdata), .t_int_req(t_int_req)
  );

  always #5 cpu_clk = ~cpu_clk;

  localparam logic [1:0] START = 2'b00, STOP = 2'b01, SNAP = 2'b10, ACK = 2'b11;

  typedef struct {
    int          cyc;
    logic [2:0]  adrs;
    logic [15:0] data;
  } wr_t;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] value;
    logic [15:0] hi;
    logic [15:0] lo;
    int          noise;
    int          exp_lat;
    logic [15:0] exp_first;
    logic [31:0] exp_rd;
  } vec_t;

  int n_checks = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Timer slave model: the read data is registered one cycle after the
  // address. An interrupt stays pending until an ack write reaches it.
  logic [15:0] tim_hi = 16'h0, tim_lo = 16'h0;
  int irq_raise = 0;
  int irq_ack = 0;
  assign t_int_req = (irq_raise != irq_ack);

  always @(posedge cpu_clk) begin
    t_rdata <= (t_cs && !t_we) ? ((t_adrs == 3'd0) ? tim_hi : (t_adrs == 3'd1) ? tim_lo : 16'h0)
                               : 16'h0;
    if (t_cs && t_we && t_adrs == 3'd4 && !t_wdata[0] && t_int_req) irq_ack <= irq_ack + 1;
  end

  // Command-level reference state.
  bit          rs_m = 1'b0;
  int          tick_m = 0;
  logic [31:0] rd_m = 32'h0;

  // Side results of run_cmd.
  int          last_lat, pre_wait, pre_ticks, pre_busy;
  logic [15:0] last_first;

  function automatic wr_t mk(input int c, input logic [2:0] a, input logic [15:0] d);
    wr_t w;
    w.cyc = c; w.adrs = a; w.data = d;
    return w;
  endfunction

  // Issue one host command and hold cmd_valid until it is accepted. Then log
  // every write on the timer port until done, and compare the log with the
  // expected write list. noise: 0 quiet CPU, 1 random CPU strobes, 2 a held
  // CPU write of 0x0001 to the control register.
  task automatic run_cmd(input logic [1:0] op, input logic [31:0] val,
                         input int noise, input bit raise);
    wr_t got[$];
    wr_t exp[$];
    wr_t w;
    int exp_lat;
    bit acc, busy_ok;
    logic [31:0] rd_done;
    case (op)
      START: begin
        exp.push_back(mk(1, 3'd2, 16'h0002));
        exp.push_back(mk(2, 3'd0, val[31:16]));
        exp.push_back(mk(3, 3'd1, val[15:0]));
        exp.push_back(mk(4, 3'd2, 16'h0004));
        exp.push_back(mk(7, 3'd2, 16'h0001));
        exp_lat = 8;
      end
      STOP: begin exp.push_back(mk(1, 3'd2, 16'h0000)); exp_lat = 2; end
      ACK:  begin exp.push_back(mk(1, 3'd4, 16'h0000)); exp_lat = 2; end
      default: begin
        exp.push_back(mk(1, 3'd2, 16'h0008 | {15'd0, rs_m}));
        exp.push_back(mk(3, 3'd2, {15'd0, rs_m}));
        exp_lat = 6;
      end
    endcase

    @(posedge cpu_clk); #1;
    cmd_valid = 1'b1; cmd_op = op; cmd_value = val;
    cpu_cs = 1'b0; cpu_we = 1'b0;
    if (raise) irq_raise++;
    acc = 1'b0; pre_wait = 0; pre_ticks = 0; pre_busy = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge cpu_clk);
      if (tick) pre_ticks++;
      if (cpu_wait) pre_busy++;
      if (cmd_ready) begin acc = 1'b1; break; end
      pre_wait++;
      @(posedge cpu_clk); #1;
    end
    @(posedge cpu_clk); #1;
    cmd_valid = 1'b0;
    check("cmd_accepted", acc, 1'b1);
    if (!acc) return;

    busy_ok = 1'b1; last_lat = 0; rd_done = 32'h0;
    for (int n = 1; n <= 20; n++) begin
      if (noise == 1) begin
        cpu_cs = 1'($urandom); cpu_we = 1'($urandom);
        cpu_adrs = 3'($urandom); cpu_wdata = 16'($urandom);
      end else if (noise == 2) begin
        cpu_cs = 1'b1; cpu_we = 1'b1; cpu_adrs = 3'd2; cpu_wdata = 16'h0001;
      end
      @(negedge cpu_clk);
      if (!cpu_wait || cmd_ready) busy_ok = 1'b0;
      if (t_cs && t_we) begin
        w.cyc = n; w.adrs = t_adrs; w.data = t_wdata;
        got.push_back(w);
      end
      if (done) begin last_lat = n; rd_done = rd_data; break; end
      @(posedge cpu_clk); #1;
    end
    @(posedge cpu_clk); #1;
    cpu_cs = 1'b0; cpu_we = 1'b0;

    if (op == START) rs_m = 1'b1;
    if (op == STOP)  rs_m = 1'b0;
    if (op == SNAP)  rd_m = {tim_hi, tim_lo};

    check("latency", last_lat, exp_lat);
    check("busy_during_seq", busy_ok, 1'b1);
    check("write_count", got.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      check("write_cycle", got[i].cyc, exp[i].cyc);
      check("write_adrs_data", {got[i].adrs, got[i].data}, {exp[i].adrs, exp[i].data});
    end
    last_first = (got.size() > 0) ? got[0].data : 16'hDEAD;
    if (op == SNAP) check("rd_data_with_done", rd_done, rd_m);

    @(negedge cpu_clk);
    check("ready_after_done", cmd_ready, 1'b1);
    check("rd_data_held", rd_data, rd_m);
  endtask

  // Raise one timer interrupt with auto_ack=1 and expect a self-acknowledge.
  task automatic auto_tick();
    bit seen, acked;
    @(posedge cpu_clk); #1;
    cmd_valid = 1'b0; cpu_cs = 1'b0;
    irq_raise++;
    @(negedge cpu_clk);
    check("irq_masked", irq, 1'b0);
    check("ready_blocked_by_irq", cmd_ready, 1'b0);
    seen = 1'b0; acked = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(posedge cpu_clk); #1;
      @(negedge cpu_clk);
      if (t_cs && t_we && t_adrs == 3'd4 && t_wdata == 16'h0) acked = 1'b1;
      if (tick) begin
        seen = 1'b1;
        check("no_done_on_auto", done, 1'b0);
      end
    end
    check("auto_tick_seen", seen, 1'b1);
    check("auto_ack_write", acked, 1'b1);
    tick_m = (tick_m + 1) % (1 << TW);
    @(posedge cpu_clk); #1;
    @(negedge cpu_clk);
    check("tick_single_pulse", tick, 1'b0);
    check("tick_count", tick_count, tick_m);
  endtask

  // One passthrough CPU cycle in IDLE with random strobes.
  task automatic cpu_idle();
    @(posedge cpu_clk); #1;
    cpu_cs = 1'($urandom); cpu_we = 1'($urandom);
    cpu_adrs = 3'($urandom); cpu_wdata = 16'($urandom);
    @(negedge cpu_clk);
    check("passthrough", {t_cs, t_we, t_adrs, t_wdata}, {cpu_cs, cpu_we, cpu_adrs, cpu_wdata});
    check("cpu_rdata", cpu_rdata, t_rdata);
    check("idle_no_wait", cpu_wait, 1'b0);
    if (cpu_cs && cpu_we && cpu_adrs == 3'd2) rs_m = cpu_wdata[0];
    @(posedge cpu_clk); #1;
    cpu_cs = 1'b0; cpu_we = 1'b0;
  endtask

  vec_t vecs[7];
  int   r;

  initial begin
    vecs[0] = '{START, 32'h0001_0005, 16'h0000, 16'h0000, 0, 8, 16'h0002, 32'h0000_0000};
    vecs[1] = '{SNAP,  32'h0,         16'h00AB, 16'h1234, 1, 6, 16'h0009, 32'h00AB_1234};
    vecs[2] = '{STOP,  32'h0,         16'h0000, 16'h0000, 0, 2, 16'h0000, 32'h00AB_1234};
    vecs[3] = '{SNAP,  32'h0,         16'hFFFF, 16'h0000, 1, 6, 16'h0008, 32'hFFFF_0000};
    vecs[4] = '{ACK,   32'h0,         16'h0000, 16'h0000, 0, 2, 16'h0000, 32'hFFFF_0000};
    vecs[5] = '{START, 32'hFFFF_FFFF, 16'h0000, 16'h0000, 1, 8, 16'h0002, 32'hFFFF_0000};
    vecs[6] = '{SNAP,  32'h0,         16'h0000, 16'h0001, 0, 6, 16'h0009, 32'h0000_0001};

    cmd_valid = 1'b0; cmd_op = 2'b00; cmd_value = 32'h0; auto_ack = 1'b0;
    cpu_cs = 1'b1; cpu_we = 1'b0; cpu_adrs = 3'd3; cpu_wdata = 16'h1234;

    // Reset state.
    #12;
    check("rst_outputs_zero", {done, tick, irq, cpu_wait, 28'(tick_count)}, 32'h0);
    check("rst_rd_data", rd_data, 32'h0);
    check("rst_cmd_ready", cmd_ready, 1'b1);
    check("rst_passthrough", {t_cs, t_we, t_adrs, t_wdata}, {1'b1, 1'b0, 3'd3, 16'h1234});
    @(negedge cpu_clk);
    rst = 1'b1;
    cpu_cs = 1'b0;

    // Table of command vectors.
    for (int i = 0; i < 7; i++) begin
      tim_hi = vecs[i].hi; tim_lo = vecs[i].lo;
      run_cmd(vecs[i].op, vecs[i].value, vecs[i].noise, 1'b0);
      check("vec_latency", last_lat, vecs[i].exp_lat);
      check("vec_first_write", last_first, vecs[i].exp_first);
      check("vec_rd_data", rd_data, vecs[i].exp_rd);
    end

    // CPU control writes are blocked during sequences and pass through in IDLE.
    run_cmd(START, 32'h0002_0003, 2, 1'b0);
    run_cmd(STOP, 32'h0, 2, 1'b0);
    run_cmd(SNAP, 32'h0, 0, 1'b0);
    check("blocked_write_no_run_shadow", last_first, 16'h0008);
    @(posedge cpu_clk); #1;
    cpu_cs = 1'b1; cpu_we = 1'b1; cpu_adrs = 3'd2; cpu_wdata = 16'h0001;
    @(negedge cpu_clk);
    check("idle_ctrl_write_passes", {t_cs, t_we, t_adrs, t_wdata}, {1'b1, 1'b1, 3'd2, 16'h0001});
    @(posedge cpu_clk); #1;
    cpu_cs = 1'b0; cpu_we = 1'b0;
    rs_m = 1'b1;
    run_cmd(SNAP, 32'h0, 0, 1'b0);
    check("idle_write_sets_run_shadow", last_first, 16'h0009);

    // Three self-acknowledged interrupts.
    auto_ack = 1'b1;
    for (int i = 0; i < 3; i++) auto_tick();
    check("three_ticks", tick_count, 3);
    auto_ack = 1'b0;

    // With auto_ack=0 the interrupt reaches irq; a host ACK clears it.
    @(posedge cpu_clk); #1;
    irq_raise++;
    @(negedge cpu_clk);
    check("irq_follows_req", irq, 1'b1);
    check("ready_with_irq_no_auto", cmd_ready, 1'b1);
    run_cmd(ACK, 32'h0, 0, 1'b0);
    check("irq_cleared_by_ack", irq, 1'b0);

    // The interrupt and a STOP arrive together: the self-ack runs first.
    auto_ack = 1'b1;
    run_cmd(STOP, 32'h0, 0, 1'b1);
    tick_m = (tick_m + 1) % (1 << TW);
    check("ack_before_stop_wait", pre_wait, 3);
    check("ack_before_stop_tick", pre_ticks, 1);
    check("ack_before_stop_busy", pre_busy, 2);
    check("tick_after_collision", tick_count, tick_m);

    // Tick counter wrap-around.
    for (int i = 0; i < 20 && tick_m != (1 << TW) - 1; i++) auto_tick();
    check("tick_at_max", tick_count, (1 << TW) - 1);
    auto_tick();
    check("tick_wrapped", tick_count, 0);
    auto_ack = 1'b0;

    // Randomized traffic.
    for (int it = 0; it < 40; it++) begin
      r = $urandom_range(0, 5);
      tim_hi = 16'($urandom); tim_lo = 16'($urandom);
      if (r < 4) begin
        run_cmd(2'($urandom_range(0, 3)), $urandom, 1, 1'b0);
      end else if (r == 4) begin
        cpu_idle();
      end else begin
        auto_ack = 1'b1;
        auto_tick();
        auto_ack = 1'b0;
      end
    end

    // Make sure rd_data and tick_count are non-zero before the reset test.
    tim_hi = 16'hC0DE; tim_lo = 16'hBEEF;
    run_cmd(SNAP, 32'h0, 0, 1'b0);
    auto_ack = 1'b1;
    if (tick_m == 0) auto_tick();
    auto_ack = 1'b0;

    // Asynchronous reset at START step 3.
    @(posedge cpu_clk); #1;
    cmd_valid = 1'b1; cmd_op = START; cmd_value = 32'h1234_5678;
    @(negedge cpu_clk);
    check("reset_test_ready", cmd_ready, 1'b1);
    @(posedge cpu_clk); #1;
    cmd_valid = 1'b0;
    cpu_cs = 1'b1; cpu_we = 1'b1; cpu_adrs = 3'd5; cpu_wdata = 16'h5A5A;
    repeat (3) @(posedge cpu_clk);
    #3;
    check("step3_before_reset", {t_cs, t_we, t_adrs, t_wdata}, {1'b1, 1'b1, 3'd2, 16'h0004});
    rst = 1'b0;
    #1;
    check("async_rst_outputs", {done, tick, irq, cpu_wait, 28'(tick_count)}, 32'h0);
    check("async_rst_rd_data", rd_data, 32'h0);
    check("async_rst_ready", cmd_ready, 1'b1);
    check("async_rst_passthrough", {t_cs, t_we, t_adrs, t_wdata}, {1'b1, 1'b1, 3'd5, 16'h5A5A});
    @(negedge cpu_clk);
    rst = 1'b1;
    cpu_cs = 1'b0; cpu_we = 1'b0;
    rs_m = 1'b0; tick_m = 0; rd_m = 32'h0;
    run_cmd(STOP, 32'h0, 0, 1'b0);
    check("stop_after_reset_latency", last_lat, 2);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
